// File: rtl/guess_target_gen.sv
// guess_target_gen: input stage of the number-guessing game.
// Conditions btnC/btnU (2-flop sync, debounce, rising-edge pulse) and runs a free-running
// 16-bit Galois LFSR. On each accepted btnU press it captures an 8-bit target and converts
// it to three BCD digits, one double-dabble iteration per cycle.
//
// Optional build macro GUESS_TGEN_NONZERO_EN: when defined, a sampled value of 0 is rejected
// in CAPTURE and the LFSR is resampled on the next cycle, so 0 is never published.
//
// Handshake: there is no valid/ready pair here. new_target is a 1-cycle strobe that fires in
// the first cycle the new target and digits are visible. Consumers may read target/bcd_* at
// any time; they only change together on that strobe. target_valid stays high once the first
// target has been published. busy covers CAPTURE and CONVERT; btnU presses while the FSM is
// not in IDLE are dropped.
//
// state_dbg mirrors the FSM state register (0 IDLE, 1 CAPTURE, 2 CONVERT, 3 DONE).

module guess_target_gen #(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC,
    input  logic       btnU,
    output logic       start,
    output logic [7:0] target,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       target_valid,
    output logic       new_target,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // An all-zero seed would lock the LFSR, so it is replaced with 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Index 0 = btnC, index 1 = btnU.
    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         level;
    logic [1:0]         level_d;
    logic [1:0][CW-1:0] db_cnt;
    logic [1:0]         press;
    logic               press_c;
    logic               press_u;

    logic [15:0] lfsr;
    state_t      state;
    logic [7:0]  cand;
    logic [19:0] dd;
    logic [19:0] dd_next;
    logic [2:0]  iter;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
    function automatic logic [19:0] dabble_step(input logic [19:0] d);
        logic [19:0] a;
        a = d;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    assign raw       = {btnU, btnC};
    assign press     = level & ~level_d;
    assign press_c   = press[0];
    assign press_u   = press[1];
    assign dd_next   = dabble_step(dd);
    assign state_dbg = state;

    // Synchronize both buttons, then accept a new level only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            db_cnt  <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Free-running Galois LFSR, shifting every cycle regardless of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // Sticky game-started flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start <= 1'b0;
        end else if (press_c) begin
            start <= 1'b1;
        end
    end

    // Capture/convert/publish FSM. The publish happens on the edge that completes the 8th
    // iteration so new_target and the digits appear together in the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cand         <= '0;
            dd           <= '0;
            iter         <= '0;
            busy         <= 1'b0;
            new_target   <= 1'b0;
            target_valid <= 1'b0;
            target       <= '0;
            bcd_hund     <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    new_target <= 1'b0;
                    // start is the value registered before this edge; a simultaneous
                    // btnC press suppresses the btnU press.
                    if (press_u && start && !press_c) begin
                        state <= S_CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
`ifdef GUESS_TGEN_NONZERO_EN
                    if (lfsr[7:0] != 8'h00) begin
                        cand  <= lfsr[7:0];
                        dd    <= {12'h000, lfsr[7:0]};
                        iter  <= '0;
                        state <= S_CONVERT;
                    end
`else
                    cand  <= lfsr[7:0];
                    dd    <= {12'h000, lfsr[7:0]};
                    iter  <= '0;
                    state <= S_CONVERT;
`endif
                end
                S_CONVERT: begin
                    dd   <= dd_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        new_target   <= 1'b1;
                        target_valid <= 1'b1;
                        target       <= cand;
                        bcd_hund     <= dd_next[19:16];
                        bcd_tens     <= dd_next[15:12];
                        bcd_ones     <= dd_next[11:8];
                    end
                end
                S_DONE: begin
                    new_target <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_target_gen.sv
// Bench for guess_target_gen with DEBOUNCE_CYCLES=4. Carries its own LFSR model and
// predicts each published target from the btnU rise cycle: 2 sync + 4 debounce cycles to
// the press pulse, capture one cycle later, new_target 10 cycles after the press.

module tb_guess_target_gen;

    localparam int          DB   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnC = 1'b0;
    logic       btnU = 1'b0;
    logic       start;
    logic [7:0] target;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       target_valid;
    logic       new_target;
    logic       busy;
    logic [1:0] state_dbg;

    guess_target_gen #(
        .DEBOUNCE_CYCLES(DB),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btnC        (btnC),
        .btnU        (btnU),
        .start       (start),
        .target      (target),
        .bcd_hund    (bcd_hund),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .target_valid(target_valid),
        .new_target  (new_target),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // clock / reference model
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr;
    int          cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         nt_cnt   = 0;
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (new_target === 1'b1) begin
            nt_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_new_target", new_target, 0);
            end else begin
                int e;
                int c;
                e = int'(exp_q.pop_front());
                c = exp_cyc_q.pop_front();
                check_eq("latency", cyc, c);
                check_eq("target", target, e);
                check_eq("bcd_hund", bcd_hund, e / 100);
                check_eq("bcd_tens", bcd_tens, (e / 10) % 10);
                check_eq("bcd_ones", bcd_ones, e % 10);
                check_eq("target_valid", target_valid, 1);
                check_eq("busy_at_done", busy, 0);
            end
        end
    end

    // driver tasks
    // Called at a negedge: predicts the capture, then holds btnU for 'hold' cycles.
    task automatic press_u_conv(input int hold);
        logic [15:0] s;
        int          rej;
        s = m_lfsr;
        repeat (7) s = lfsr_step(s);
        rej = 0;
`ifdef GUESS_TGEN_NONZERO_EN
        while (s[7:0] == 8'h00) begin
            s = lfsr_step(s);
            rej++;
        end
`endif
        exp_q.push_back(s[7:0]);
        exp_cyc_q.push_back(cyc + 16 + rej);
        btnU = 1'b1;
        repeat (hold) @(negedge clk);
        btnU = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) @(negedge clk);
        check_eq("sb_drain", exp_q.size(), 0);
    endtask

    // Waits until a press starting now would capture 'want', then presses.
    task automatic press_for(input logic [7:0] want, output bit found);
        logic [15:0] s;
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            s = m_lfsr;
            repeat (7) s = lfsr_step(s);
            if (s[7:0] == want) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("search", found, 1);
        if (found) begin
            press_u_conv(8);
            drain(40);
            repeat (12) @(negedge clk);
        end
    endtask

    // stimulus
    logic [7:0] want_tab [4] = '{8'd255, 8'd100, 8'd9, 8'd0};
    logic [3:0] hund_tab [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
    logic [3:0] tens_tab [4] = '{4'd5, 4'd0, 4'd0, 4'd0};
    logic [3:0] ones_tab [4] = '{4'd5, 4'd0, 4'd9, 4'd0};

    initial begin
        int         b0;
        int         n0;
        logic [7:0] prev;
        bit         found;

        repeat (3) @(negedge clk);
        check_eq("rst_start", start, 0);
        check_eq("rst_target", target, 0);
        check_eq("rst_hund", bcd_hund, 0);
        check_eq("rst_tens", bcd_tens, 0);
        check_eq("rst_ones", bcd_ones, 0);
        check_eq("rst_valid", target_valid, 0);
        check_eq("rst_new_target", new_target, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", state_dbg, 0);
        rst = 1'b0;

        // btnU before any btnC: ignored
        @(negedge clk);
        b0 = busy_cnt;
        n0 = nt_cnt;
        btnU = 1'b1;
        repeat (8) @(negedge clk);
        btnU = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("prestart_busy", busy_cnt - b0, 0);
        check_eq("prestart_new_target", nt_cnt - n0, 0);

        // btnC held 8 cycles: start rises 7 cycles after the rise
        btnC = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("start_early", start, 0);
        @(negedge clk);
        check_eq("start_set", start, 1);
        @(negedge clk);
        btnC = 1'b0;
        repeat (12) @(negedge clk);

        // btnU held 20 cycles: exactly one conversion
        n0 = nt_cnt;
        press_u_conv(20);
        drain(40);
        repeat (12) @(negedge clk);
        check_eq("held_one_new_target", nt_cnt - n0, 1);

        // 3-cycle glitch: no press
        b0 = busy_cnt;
        btnU = 1'b1;
        repeat (3) @(negedge clk);
        btnU = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("glitch_busy", busy_cnt - b0, 0);

        // second press lands while busy and is dropped
        n0 = nt_cnt;
        prev = target;
        press_u_conv(4);
        repeat (4) @(negedge clk);
        btnU = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("busy_mid_conv", busy, 1);
        check_eq("hold_target", target, prev);
        btnU = 1'b0;
        drain(40);
        repeat (30) @(negedge clk);
        check_eq("dropped_press", nt_cnt - n0, 1);

        // async reset mid-conversion: everything clears, no partial publish
        press_u_conv(8);
        check_eq("busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_start", start, 0);
        check_eq("async_target", target, 0);
        check_eq("async_hund", bcd_hund, 0);
        check_eq("async_tens", bcd_tens, 0);
        check_eq("async_ones", bcd_ones, 0);
        check_eq("async_valid", target_valid, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_state", state_dbg, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        n0 = nt_cnt;
        repeat (20) @(negedge clk);
        check_eq("abort_no_publish", nt_cnt - n0, 0);
        check_eq("abort_busy", busy, 0);

        // btnC and btnU together: start only, no conversion
        b0 = busy_cnt;
        n0 = nt_cnt;
        btnC = 1'b1;
        btnU = 1'b1;
        repeat (8) @(negedge clk);
        btnC = 1'b0;
        btnU = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("same_cycle_start", start, 1);
        check_eq("same_cycle_busy", busy_cnt - b0, 0);
        check_eq("same_cycle_new_target", nt_cnt - n0, 0);

        // next press converts; model restarted from the seed at reset
        press_u_conv(8);
        drain(40);
        repeat (12) @(negedge clk);

        // boundary targets
        for (int k = 0; k < 4; k++) begin
            press_for(want_tab[k], found);
            if (found) begin
`ifdef GUESS_TGEN_NONZERO_EN
                if (want_tab[k] == 8'd0) begin
                    check_eq("nonzero_target", (target != 8'd0), 1);
                end else begin
                    check_eq("want_target", target, want_tab[k]);
                    check_eq("want_hund", bcd_hund, hund_tab[k]);
                    check_eq("want_tens", bcd_tens, tens_tab[k]);
                    check_eq("want_ones", bcd_ones, ones_tab[k]);
                end
`else
                check_eq("want_target", target, want_tab[k]);
                check_eq("want_hund", bcd_hund, hund_tab[k]);
                check_eq("want_tens", bcd_tens, tens_tab[k]);
                check_eq("want_ones", bcd_ones, ones_tab[k]);
`endif
            end
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
